// File: rtl/char_shift_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : char_buf_pkg                                               |
// | Description : Shared defaults and helpers for the character display      |
// |               buffer: default slot width, default blank code and the     |
// |               width of a fill counter able to hold 0..DEPTH.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package char_buf_pkg;

   // 7-seg code including the decimal point
   localparam int         C_CHAR_W_DEFAULT = 8;
   // all segments off
   localparam logic [7:0] C_BLANK_DEFAULT  = 8'h00;

   // Bits needed to represent every fill level from 0 up to and including depth.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/char_shift_buffer_rise_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rise_edge                                                  |
// | Description : Rising-edge detector. Registers the level once per clock   |
// |               and flags the cycle in which the level is high but was low |
// |               at the previous clock, so a held level acts only once.     |
// | Ports       : clk   in  system clock                                     |
// |               rst_n in  async active-low reset (history cleared to 0)    |
// |               level in  level input to watch                             |
// |               rise  out level & ~previous level (combinational)          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rise_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise
);

   logic r_level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level_q <= 1'b0;
      end else begin
         r_level_q <= level;
      end
   end

   assign rise = level & ~r_level_q;

endmodule
`default_nettype wire

// File: rtl/char_shift_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : char_shift_buffer                                          |
// | Description : Display buffer for decoded Morse characters. Holds up to   |
// |               DEPTH codes, newest in slot 0. Supports append, backspace, |
// |               in-place edit (append + backspace together) and clear,     |
// |               with a selectable drop/scroll policy when full.            |
// | Ports       : clk       in  system clock                                 |
// |               rst_n     in  async active-low reset                       |
// |               push      in  level, rising edge appends char_in           |
// |               backspace in  level, rising edge removes newest char       |
// |               clear     in  level, empties buffer while high             |
// |               char_in   in  code to append / edit                        |
// |               buf_out   out slot i at [i*CHAR_W +: CHAR_W], 0 = newest   |
// |               disp_out  out buf_out, newest char optionally blinked      |
// |               count     out number of valid characters                   |
// |               full      out count == DEPTH                               |
// |               empty     out count == 0                                   |
// |               overflow  out one-cycle pulse on a push at full            |
// | Config      : CHAR_SHIFT_BUFFER_CURSOR_BLINK_EN - when defined, slot 0   |
// |               of disp_out blinks with a half-period of 2**BLINK_DIV clk. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module char_shift_buffer
   import char_buf_pkg::*;
#(
   parameter int                DEPTH     = 8,
   parameter int                CHAR_W    = C_CHAR_W_DEFAULT,
   parameter logic [CHAR_W-1:0] BLANK     = CHAR_W'(C_BLANK_DEFAULT),
   parameter bit                OVERWRITE = 1'b1,
   parameter int                BLINK_DIV = 25
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            push,
   input  logic                            backspace,
   input  logic                            clear,
   input  logic [CHAR_W-1:0]               char_in,
   output logic [DEPTH*CHAR_W-1:0]         buf_out,
   output logic [DEPTH*CHAR_W-1:0]         disp_out,
   output logic [count_width(DEPTH)-1:0]   count,
   output logic                            full,
   output logic                            empty,
   output logic                            overflow
);

   localparam int              C_CW    = count_width(DEPTH);
   localparam logic [C_CW-1:0] C_DEPTH = C_CW'(DEPTH);

   logic              w_push_e;
   logic              w_bs_e;
   logic [CHAR_W-1:0] r_slot     [DEPTH];
   logic [CHAR_W-1:0] w_slot_nxt [DEPTH];
   logic [C_CW-1:0]   r_count;
   logic [C_CW-1:0]   w_count_nxt;
   logic              r_overflow;
   logic              w_overflow_nxt;
   logic              w_commit;
   logic              w_is_full;
   logic              w_is_empty;
   logic              w_blink_off;

   rise_edge u_push_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .level (push),
      .rise  (w_push_e)
   );

   rise_edge u_bs_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .level (backspace),
      .rise  (w_bs_e)
   );

   assign w_is_full  = (r_count == C_DEPTH);
   assign w_is_empty = (r_count == '0);

   // w_commit marks any action that changed the newest character, which is
   // what restarts the cursor blink phase. A push dropped at full and a clear
   // are not commits.
   always_comb begin
      w_slot_nxt     = r_slot;
      w_count_nxt    = r_count;
      w_overflow_nxt = 1'b0;
      w_commit       = 1'b0;
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            w_slot_nxt[i] = BLANK;
         end
         w_count_nxt = '0;
      end else if (w_push_e && w_bs_e && !w_is_empty) begin
         // edit: replace newest in place; an empty buffer falls to plain push
         w_slot_nxt[0] = char_in;
         w_commit      = 1'b1;
      end else if (w_push_e) begin
         if (w_is_full) begin
            w_overflow_nxt = 1'b1;
            if (OVERWRITE) begin
               for (int i = 1; i < DEPTH; i++) begin
                  w_slot_nxt[i] = r_slot[i-1];
               end
               w_slot_nxt[0] = char_in;
               w_commit      = 1'b1;
            end
         end else begin
            for (int i = 1; i < DEPTH; i++) begin
               w_slot_nxt[i] = r_slot[i-1];
            end
            w_slot_nxt[0] = char_in;
            w_count_nxt   = r_count + C_CW'(1);
            w_commit      = 1'b1;
         end
      end else if (w_bs_e && !w_is_empty) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            w_slot_nxt[i] = r_slot[i+1];
         end
         w_slot_nxt[DEPTH-1] = BLANK;
         w_count_nxt         = r_count - C_CW'(1);
         w_commit            = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_slot[i] <= BLANK;
         end
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_slot     <= w_slot_nxt;
         r_count    <= w_count_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

`ifdef CHAR_SHIFT_BUFFER_CURSOR_BLINK_EN
   // Free-running phase counter; its MSB selects the "off" half-period.
   // Restarting on a commit makes a freshly entered char visible at once.
   logic [BLINK_DIV:0] r_blink_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
      end else if (w_commit) begin
         r_blink_cnt <= '0;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   assign w_blink_off = r_blink_cnt[BLINK_DIV] & ~w_is_empty;
`else
   logic w_unused_cfg;

   assign w_blink_off  = 1'b0;
   assign w_unused_cfg = w_commit ^ (BLINK_DIV != 0);
`endif

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign buf_out[gi*CHAR_W +: CHAR_W] = r_slot[gi];
      if (gi == 0) begin : g_head
         assign disp_out[gi*CHAR_W +: CHAR_W] = w_blink_off ? BLANK : r_slot[gi];
      end else begin : g_tail
         assign disp_out[gi*CHAR_W +: CHAR_W] = r_slot[gi];
      end
   end

   assign count    = r_count;
   assign full     = w_is_full;
   assign empty    = w_is_empty;
   assign overflow = r_overflow;

endmodule
`default_nettype wire
